// File: rtl/iter_divider_pipe.sv
// Iterative restoring divider, BITS_PER_CYCLE quotient bits per clock,
// with ready/start/done handshake and explicit divide-by-zero flag.
// Ports: clk, rst (async, active-high), start, numerator, divisor,
//   [signed_op], ready, quotient, remainder, done, div_by_zero.
// Option: define ITER_DIV_SIGNED_EN to add signed_op (two's complement).
module iter_divider_pipe #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0] divisor,
`ifdef ITER_DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             div_by_zero
);

  localparam int ITER = WIDTH / BITS_PER_CYCLE;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int PW   = WIDTH + BITS_PER_CYCLE;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ZERO
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]          num_q;
  logic [WIDTH-1:0]          den_q;
  logic [PW-1:0]             rem_q;
  logic [WIDTH-1:0]          quo_q;
  logic [CW-1:0]             cnt;
  logic                      last;

  logic [PW-1:0]             part;
  logic [WIDTH-1:0]          num_sh;
  logic [BITS_PER_CYCLE-1:0] qbits;
  logic [WIDTH-1:0]          quo_nx;
  logic [WIDTH-1:0]          q_fix;
  logic [WIDTH-1:0]          r_fix;
  logic [WIDTH-1:0]          n_mag;
  logic [WIDTH-1:0]          d_mag;

  assign ready = (state == IDLE);
  assign last  = (cnt == CW'(ITER - 1));

`ifdef ITER_DIV_SIGNED_EN
  logic n_neg, d_neg;
  logic neg_q, neg_r;

  assign n_neg = signed_op & numerator[WIDTH-1];
  assign d_neg = signed_op & divisor[WIDTH-1];
  assign n_mag = n_neg ? -numerator : numerator;
  assign d_mag = d_neg ? -divisor : divisor;
  // Signs applied on the result write itself: no extra cycle.
  assign q_fix = neg_q ? -quo_nx : quo_nx;
  assign r_fix = neg_r ? -part[WIDTH-1:0] : part[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (ready && start) begin
      neg_q <= n_neg ^ d_neg;
      neg_r <= n_neg;
    end
  end
`else
  assign n_mag = numerator;
  assign d_mag = divisor;
  assign q_fix = quo_nx;
  assign r_fix = part[WIDTH-1:0];
`endif

  // Chained trial subtractions, MSB quotient bit first.
  always_comb begin
    part   = rem_q;
    num_sh = num_q;
    qbits  = '0;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      part   = {part[PW-2:0], num_sh[WIDTH-1]};
      num_sh = {num_sh[WIDTH-2:0], 1'b0};
      if (part >= {{BITS_PER_CYCLE{1'b0}}, den_q}) begin
        part     = part - {{BITS_PER_CYCLE{1'b0}}, den_q};
        qbits[i] = 1'b1;
      end
    end
  end

  generate
    if (WIDTH > BITS_PER_CYCLE) begin : g_qshift
      assign quo_nx = {quo_q[WIDTH-BITS_PER_CYCLE-1:0], qbits};
    end else begin : g_qone
      assign quo_nx = qbits;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = (divisor == '0) ? ZERO : CALC;
      CALC: if (last) state_nx = IDLE;
      ZERO: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q       <= '0;
      den_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          // ZERO path reports the raw numerator back.
          num_q <= (divisor == '0) ? numerator : n_mag;
          den_q <= d_mag;
          rem_q <= '0;
          quo_q <= '0;
          cnt   <= '0;
        end
        CALC: begin
          num_q <= num_sh;
          rem_q <= part;
          quo_q <= quo_nx;
          cnt   <= cnt + CW'(1);
          if (last) begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            done        <= 1'b1;
            div_by_zero <= 1'b0;
            cnt         <= '0;
          end
        end
        ZERO: begin
          quotient    <= '1;
          remainder   <= num_q;
          done        <= 1'b1;
          div_by_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider_pipe.sv
// Self-checking bench for iter_divider_pipe at 1, 2 and 4 bits/cycle.
// Directed steps plus random operands against an arithmetic model.
module tb_iter_divider_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] numerator;
  logic [31:0] divisor;
  logic        signed_op;

  logic        start_a [3];
  logic        rdy_a   [3];
  logic        done_a  [3];
  logic        dbz_a   [3];
  logic [31:0] q_a     [3];
  logic [31:0] r_a     [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iter_divider_pipe #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_b1 (
    .clk(clk), .rst(rst), .start(start_a[0]),
    .numerator(numerator), .divisor(divisor),
`ifdef ITER_DIV_SIGNED_EN
    .signed_op(signed_op),
`endif
    .ready(rdy_a[0]), .quotient(q_a[0]), .remainder(r_a[0]),
    .done(done_a[0]), .div_by_zero(dbz_a[0])
  );

  iter_divider_pipe #(.WIDTH(32), .BITS_PER_CYCLE(2)) u_b2 (
    .clk(clk), .rst(rst), .start(start_a[1]),
    .numerator(numerator), .divisor(divisor),
`ifdef ITER_DIV_SIGNED_EN
    .signed_op(signed_op),
`endif
    .ready(rdy_a[1]), .quotient(q_a[1]), .remainder(r_a[1]),
    .done(done_a[1]), .div_by_zero(dbz_a[1])
  );

  iter_divider_pipe #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_b4 (
    .clk(clk), .rst(rst), .start(start_a[2]),
    .numerator(numerator), .divisor(divisor),
`ifdef ITER_DIV_SIGNED_EN
    .signed_op(signed_op),
`endif
    .ready(rdy_a[2]), .quotient(q_a[2]), .remainder(r_a[2]),
    .done(done_a[2]), .div_by_zero(dbz_a[2])
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input  logic [31:0] n,
                                input  logic [31:0] d,
                                input  logic        s,
                                output logic [31:0] q,
                                output logic [31:0] r);
    longint sn, sd, sq, sr;
    if (d == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = n;
    end else if (s) begin
      sn = longint'($signed(n));
      sd = longint'($signed(d));
      sq = sn / sd;
      sr = sn % sd;
      q  = sq[31:0];
      r  = sr[31:0];
    end else begin
      q = n / d;
      r = n % d;
    end
  endfunction

  // Called one step after a rising edge; returns in the done cycle,
  // or one cycle later when tail is set.
  task automatic op(input int          k,
                    input logic [31:0] n,
                    input logic [31:0] d,
                    input logic        s,
                    input logic [31:0] eq,
                    input logic [31:0] er,
                    input logic        edbz,
                    input int          elat,
                    input bit          poke,
                    input bit          tail);
    int lat;
    bit rbad;
    numerator  = n;
    divisor    = d;
    signed_op  = s;
    start_a[k] = 1'b1;
    check("ready_at_issue", 32'(rdy_a[k]), 32'd1);
    @(posedge clk);
    #1;
    start_a[k] = 1'b0;
    numerator  = $urandom;
    divisor    = $urandom;
    signed_op  = 1'($urandom);
    lat  = 0;
    rbad = 1'b0;
    while (done_a[k] !== 1'b1 && lat < 100) begin
      if (rdy_a[k] !== 1'b0) rbad = 1'b1;
      if (poke && lat == 3) begin
        start_a[k] = 1'b1;
        numerator  = 32'd5;
        divisor    = 32'd9;
      end
      if (poke && lat == 6) start_a[k] = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    start_a[k] = 1'b0;
    check("latency", 32'(lat), 32'(elat));
    check("ready_low_busy", 32'(rbad), 32'd0);
    check("quotient", q_a[k], eq);
    check("remainder", r_a[k], er);
    check("div_by_zero", 32'(dbz_a[k]), 32'(edbz));
    check("ready_in_done", 32'(rdy_a[k]), 32'd1);
    if (tail) begin
      @(posedge clk);
      #1;
      check("done_width", 32'(done_a[k]), 32'd0);
    end
  endtask

  task automatic rand_ops(input int k, input int cnt, input int iter);
    logic [31:0] n, d, eq, er;
    logic        s;
    for (int i = 0; i < cnt; i++) begin
      n = $urandom;
      d = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) d = 32'd0;
      if ($urandom_range(0, 7) == 0) n = n >> $urandom_range(0, 31);
`ifdef ITER_DIV_SIGNED_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      model(n, d, s, eq, er);
      op(k, n, d, s, eq, er, d == 32'd0,
         (d == 32'd0) ? 1 : iter, 1'b0, 1'b0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    rst       = 1'b1;
    numerator = '0;
    divisor   = '0;
    signed_op = 1'b0;
    for (int i = 0; i < 3; i++) start_a[i] = 1'b0;
    #2;
    check("rst_ready", 32'(rdy_a[0]), 32'd1);
    check("rst_done", 32'(done_a[0]), 32'd0);
    check("rst_dbz", 32'(dbz_a[0]), 32'd0);
    check("rst_quot", q_a[0], 32'd0);
    check("rst_rem", r_a[0], 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    op(0, 123456, 123, 0, 1003, 87, 0, 32, 0, 1);
    op(0, 32'hFFFF_FFFF, 65535, 0, 65537, 0, 0, 32, 0, 0);
    op(0, 1000, 3, 0, 333, 1, 0, 32, 0, 1);
    op(0, 50000000, 0, 0, 32'hFFFF_FFFF, 50000000, 1, 1, 0, 1);
    op(0, 50000000, 7, 0, 7142857, 1, 0, 32, 0, 1);
    op(0, 100, 10, 0, 10, 0, 0, 32, 1, 1);
    op(0, 3, 200, 0, 0, 3, 0, 32, 0, 1);
    op(0, 0, 17, 0, 0, 0, 0, 32, 0, 1);

    numerator  = 1000;
    divisor    = 7;
    start_a[0] = 1'b1;
    @(posedge clk);
    #1;
    start_a[0] = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_quot", q_a[0], 32'd0);
    check("midrst_rem", r_a[0], 32'd0);
    check("midrst_done", 32'(done_a[0]), 32'd0);
    check("midrst_ready", 32'(rdy_a[0]), 32'd1);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_a[0] !== 1'b0) seen = 1'b1;
    end
    check("midrst_no_done", 32'(seen), 32'd0);

    op(1, 50000000, 5000, 0, 10000, 0, 0, 16, 0, 1);
    op(2, 50000000, 5000, 0, 10000, 0, 0, 8, 0, 1);
    op(2, 50000000, 0, 0, 32'hFFFF_FFFF, 50000000, 1, 1, 0, 1);

`ifdef ITER_DIV_SIGNED_EN
    op(0, -32'sd100, 7, 1, -32'sd14, -32'sd2, 0, 32, 0, 1);
    op(0, 100, -32'sd7, 1, -32'sd14, 2, 0, 32, 0, 1);
    op(1, 32'h8000_0000, 32'hFFFF_FFFF, 1,
       32'h8000_0000, 0, 0, 16, 0, 1);
    op(2, -32'sd9, 0, 1, 32'hFFFF_FFFF, -32'sd9, 1, 1, 0, 1);
`endif

    rand_ops(0, 500, 32);
    rand_ops(1, 1000, 16);
    rand_ops(2, 1500, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
